// File: rtl/jp4diff_tile_reader_pkg.sv
// Shared JP4-diff definitions: tile geometry, FSM encodings, read tags,
// the permuted tile-buffer address helper and the 0..255 clamp.
package jp4diff_tile_reader_pkg;

  localparam int TILE_PIX  = 256;
  localparam int PLANE_PIX = 64;
  localparam int Y_OFFSET  = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // Travels alongside each tile-buffer read until its data returns.
  typedef struct packed {
    logic       v;
    logic       emit;
    logic [1:0] p;
    logic [5:0] idx;
    logic       first;
    logic       last;
  } rd_tag_t;

  function automatic logic [7:0] jp4_tile_addr(
    input logic [3:0] r,
    input logic [3:0] k
  );
    return {r[0], r[3:1], k[0], k[3:1]};
  endfunction

  function automatic logic [7:0] sat8(input logic signed [10:0] x);
    if (x < 0)
      return 8'd0;
    else if (x > 11'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

endpackage

// File: rtl/jp4diff_tile_reader_base_ram.sv
// 64x8 base-plane store: one synchronous write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (combinational read).
module jp4diff_tile_reader_base_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [64];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/jp4diff_tile_reader.sv
// JP4-diff tile reader: loads the base plane, then restores a 16x16 tile
// in scanline order. Ports: tile-buffer raddr/ren/rdata, pixel dout/dv,
// status pre_first_out/busy/done, per-tile config bayer_phase/scale_diff/hdr.
module jp4diff_tile_reader
  import jp4diff_tile_reader_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [1:0] bayer_phase,
  input  logic       scale_diff,
  input  logic       hdr,
  output logic [7:0] raddr,
  output logic       ren,
  input  logic [8:0] rdata,
  output logic [7:0] dout,
  output logic       dv,
  output logic       pre_first_out,
  output logic       busy,
  output logic       done
);

  logic [1:0] state;
  logic [8:0] cnt;
  logic [1:0] bp_q;
  logic       scale_q;
  logic       hdr_q;
  logic       last_q;

  rd_tag_t tag;
  rd_tag_t pipe [RD_LAT];
  rd_tag_t fin;

  logic signed [10:0] y11;
  logic signed [10:0] ya;
  logic signed [10:0] d;
  logic signed [10:0] sum;
  logic [7:0]         b;
  logic               abs_sel;
  logic [7:0]         pix;
  logic               we;

  always_comb begin
    tag   = '0;
    raddr = 8'd0;
    if (state == ST_LOAD) begin
      tag.v   = 1'b1;
      tag.idx = cnt[5:0];
      raddr   = {bp_q[1], cnt[5:3], bp_q[0], cnt[2:0]};
    end else if (state == ST_EMIT && cnt != 9'(TILE_PIX)) begin
      tag.v     = 1'b1;
      tag.emit  = 1'b1;
      tag.p     = {cnt[4], cnt[0]};
      tag.idx   = {cnt[7:5], cnt[3:1]};
      tag.first = (cnt[7:0] == 8'd0);
      tag.last  = (cnt[7:0] == 8'hFF);
      raddr     = jp4_tile_addr(cnt[7:4], cnt[3:0]);
    end
  end

  assign ren = tag.v;
  assign fin = pipe[RD_LAT-1];

  // Restore arithmetic on the tag whose data is on rdata this clock.
  assign y11 = {{2{rdata[8]}}, rdata};
  assign ya  = y11 + 11'(Y_OFFSET);
  assign d   = scale_q ? (y11 <<< 1) : y11;
  assign sum = $signed({3'b000, b}) + d;

  assign abs_sel = (fin.p == bp_q) || (hdr_q && fin.p == ~bp_q);
  assign pix     = abs_sel ? sat8(ya) : sat8(sum);
  assign we      = fin.v && !fin.emit && en && !rst;

  jp4diff_tile_reader_base_ram u_base (
    .clk   (clk),
    .we    (we),
    .waddr (fin.idx),
    .wdata (sat8(ya)),
    .raddr (fin.idx),
    .rdata (b)
  );

  assign pre_first_out = fin.v && fin.emit && fin.first;
  assign busy          = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state   <= ST_IDLE;
      cnt     <= 9'd0;
      bp_q    <= 2'd0;
      scale_q <= 1'b0;
      hdr_q   <= 1'b0;
      last_q  <= 1'b0;
      dout    <= 8'd0;
      dv      <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < RD_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= tag;
      for (int i = 1; i < RD_LAT; i++)
        pipe[i] <= pipe[i-1];
      done   <= 1'b0;
      dv     <= fin.v && fin.emit;
      last_q <= fin.v && fin.emit && fin.last;
      if (fin.v && fin.emit)
        dout <= pix;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            cnt     <= 9'd0;
            bp_q    <= bayer_phase;
            scale_q <= scale_diff;
            hdr_q   <= hdr;
          end
        end
        ST_LOAD: begin
          cnt <= cnt + 9'd1;
          if (cnt == 9'(PLANE_PIX - 1)) begin
            state <= ST_EMIT;
            cnt   <= 9'd0;
          end
        end
        ST_EMIT: begin
          // Stay here while the read pipeline drains so busy covers the last dv.
          if (cnt != 9'(TILE_PIX))
            cnt <= cnt + 9'd1;
          if (dv && last_q) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jp4diff_tile_reader.sv
// Directed bench for jp4diff_tile_reader: table of plane-uniform tiles,
// a position-dependent model tile, and abort/reset sequences.
module tb_jp4diff_tile_reader;

  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst, en, start, scale_diff, hdr;
  logic [1:0] bayer_phase;
  logic [7:0] raddr, dout;
  logic       ren, dv, pre_first_out, busy, done;
  logic [8:0] rdata;

  always #5 clk = ~clk;

  jp4diff_tile_reader #(.RD_LAT(LAT)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .start         (start),
    .bayer_phase   (bayer_phase),
    .scale_diff    (scale_diff),
    .hdr           (hdr),
    .raddr         (raddr),
    .ren           (ren),
    .rdata         (rdata),
    .dout          (dout),
    .dv            (dv),
    .pre_first_out (pre_first_out),
    .busy          (busy),
    .done          (done)
  );

  logic [8:0] tbuf [256];
  always @(posedge clk) rdata <= tbuf[raddr];

  typedef struct packed {
    logic [1:0] bp;
    logic       sc;
    logic       hd;
    logic [8:0] yb;
    logic [8:0] yd;
    logic [8:0] yh;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] e3;
  } vec_t;

  vec_t vecs [9];

  int total = 0;
  int bad   = 0;

  int got [256];
  int exp_arr [256];
  int la [64];
  int ea [256];
  int nren, nout, t_emit, t_dv, t_pre, t_done, t_lastdv;
  int busy_bad, seen;

  task automatic chk(input string nm, input int g, input int e);
    total++;
    if (g != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask

  function automatic int addr_of(input int r, input int k);
    return (r % 2) * 128 + (r / 2) * 16 + (k % 2) * 8 + k / 2;
  endfunction

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  function automatic int clamp(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic int model(input int n, input int bp,
                               input int sc, input int h);
    int r, k, p, y, yb, bb, dd;
    r  = n / 16;
    k  = n % 16;
    p  = (r % 2) * 2 + (k % 2);
    y  = sx(tbuf[addr_of(r, k)]);
    if (p == bp || (h != 0 && p == (bp ^ 3)))
      return clamp(y + 128);
    yb = sx(tbuf[addr_of((r / 2) * 2 + bp / 2, (k / 2) * 2 + bp % 2)]);
    bb = clamp(yb + 128);
    dd = (sc != 0) ? 2 * y : y;
    return clamp(bb + dd);
  endfunction

  task automatic fill_vec(input vec_t v);
    int p, r, k;
    for (int a = 0; a < 256; a++) begin
      p = ((a >> 7) & 1) * 2 + ((a >> 3) & 1);
      if (p == int'(v.bp))
        tbuf[a] = v.yb;
      else if (p == int'(v.bp ^ 2'b11))
        tbuf[a] = v.yh;
      else
        tbuf[a] = v.yd;
    end
    for (int n = 0; n < 256; n++) begin
      r = n / 16;
      k = n % 16;
      p = (r % 2) * 2 + (k % 2);
      case (p)
        0: exp_arr[n] = int'(v.e0);
        1: exp_arr[n] = int'(v.e1);
        2: exp_arr[n] = int'(v.e2);
        default: exp_arr[n] = int'(v.e3);
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge of the done clock.
  task automatic run_tile(input logic [1:0] b, input logic s,
                          input logic h);
    bayer_phase = b;
    scale_diff  = s;
    hdr         = h;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    bayer_phase = ~b;
    scale_diff  = ~s;
    hdr         = ~h;
    nren = 0; nout = 0; t_emit = -1; t_dv = -1; t_pre = -1;
    t_done = -1; t_lastdv = -1; busy_bad = 0; seen = 0;
    for (int cyc = 1; cyc < 600; cyc++) begin
      if (ren) begin
        if (nren < 64) la[nren] = int'(raddr);
        else if (nren < 320) ea[nren-64] = int'(raddr);
        if (nren == 64) t_emit = cyc;
        nren++;
      end
      if (pre_first_out) t_pre = cyc;
      if (dv) begin
        if (nout < 256) got[nout] = int'(dout);
        if (nout == 0) t_dv = cyc;
        t_lastdv = cyc;
        nout++;
      end
      if (done) begin
        if (busy) busy_bad++;
        t_done = cyc;
        seen = 1;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge clk);
    end
  endtask

  task automatic check_tile(input string nm);
    int mism;
    mism = 0;
    for (int n = 0; n < 256; n++)
      if (got[n] != exp_arr[n]) mism++;
    chk({nm, " done_seen"}, seen, 1);
    chk({nm, " reads"}, nren, 320);
    chk({nm, " dv_count"}, nout, 256);
    chk({nm, " pix_mism"}, mism, 0);
    chk({nm, " latency"}, t_dv - t_emit, LAT + 1);
    chk({nm, " pre_first"}, t_pre, t_dv - 1);
    chk({nm, " done_time"}, t_done, t_lastdv + 1);
    chk({nm, " busy"}, busy_bad, 0);
  endtask

  initial begin
    int nr, odd, mism;
    vecs[0] = '{2'd0, 1'b0, 1'b0, 9'h000, 9'h000, 9'h000, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[1] = '{2'd0, 1'b1, 1'b0, 9'h190, 9'h1FD, 9'h1FD, 8'h10, 8'h0A, 8'h0A, 8'h0A};
    vecs[2] = '{2'd0, 1'b0, 1'b0, 9'h190, 9'h1FD, 9'h1FD, 8'h10, 8'h0D, 8'h0D, 8'h0D};
    vecs[3] = '{2'd2, 1'b0, 1'b0, 9'h070, 9'h040, 9'h040, 8'hFF, 8'hFF, 8'hF0, 8'hFF};
    vecs[4] = '{2'd3, 1'b0, 1'b0, 9'h180, 9'h1FF, 9'h1FF, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{2'd0, 1'b0, 1'b1, 9'h020, 9'h010, 9'h1E0, 8'hA0, 8'hB0, 8'hB0, 8'h60};
    vecs[6] = '{2'd0, 1'b0, 1'b0, 9'h020, 9'h010, 9'h1E0, 8'hA0, 8'hB0, 8'hB0, 8'h80};
    vecs[7] = '{2'd1, 1'b1, 1'b1, 9'h000, 9'h180, 9'h005, 8'h00, 8'h80, 8'h85, 8'h00};
    vecs[8] = '{2'd0, 1'b0, 1'b1, 9'h000, 9'h000, 9'h07F, 8'h80, 8'h80, 8'h80, 8'hFF};

    rst = 1'b1; en = 1'b1; start = 1'b0;
    bayer_phase = 2'd0; scale_diff = 1'b0; hdr = 1'b0;
    for (int a = 0; a < 256; a++) tbuf[a] = 9'h0;
    repeat (3) @(negedge clk);
    chk("reset outs",
        int'({raddr, ren, dout, dv, pre_first_out, busy, done}), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      fill_vec(vecs[i]);
      run_tile(vecs[i].bp, vecs[i].sc, vecs[i].hd);
      check_tile($sformatf("vec%0d", i));
    end

    for (int a = 0; a < 256; a++) tbuf[a] = 9'((a * 37 + 11) & 511);
    for (int n = 0; n < 256; n++) exp_arr[n] = model(n, 2, 1, 1);
    run_tile(2'd2, 1'b1, 1'b1);
    check_tile("model bp2");

    for (int n = 0; n < 256; n++) exp_arr[n] = model(n, 1, 0, 0);
    run_tile(2'd1, 1'b0, 1'b0);
    check_tile("model bp1");
    mism = 0;
    for (int j = 0; j < 64; j++)
      if (la[j] != (j / 8) * 16 + 8 + (j % 8)) mism++;
    chk("load addr bp1", mism, 0);
    mism = 0;
    for (int n = 0; n < 256; n++)
      if (ea[n] != addr_of(n / 16, n % 16)) mism++;
    chk("emit addr", mism, 0);

    // Abort with en low while EMIT n=100 is being issued.
    fill_vec(vecs[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nr = 0;
    for (int c = 0; c < 600; c++) begin
      if (ren) nr++;
      if (nr == 165) break;
      @(negedge clk);
    end
    chk("abort reached", nr, 165);
    en = 1'b0;
    @(negedge clk);
    chk("abort outs", int'({ren, dv, busy, pre_first_out, done}), 0);
    odd = 0;
    for (int c = 0; c < 20; c++) begin
      if (dv || done || ren) odd++;
      @(negedge clk);
    end
    chk("abort quiet", odd, 0);
    en = 1'b1;
    run_tile(2'd0, 1'b0, 1'b0);
    check_tile("after abort");

    // Reset in the middle of LOAD.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midload ren", int'(ren), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst midload outs",
        int'({raddr, ren, dout, dv, pre_first_out, busy, done}), 0);
    rst = 1'b0;
    run_tile(2'd0, 1'b0, 1'b0);
    check_tile("after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
